// File: rtl/switch_entry_pkg.sv
// Shared constants and FSM encoding for the switch/pushbutton hex entry path.
package switch_entry_pkg;

    localparam int unsigned NIBBLES             = 4;
    localparam int unsigned NIB_W               = 4;
    localparam int unsigned WORD_W              = NIBBLES * NIB_W;
    localparam int unsigned IDX_W               = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 200000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

endpackage

// File: rtl/switch_entry_debounce_sync.sv
// Per-bit 2-FF synchroniser, stability-counter debouncer and rising-edge pulse.
module debounce_sync #(
    parameter int unsigned WIDTH           = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 200000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q,  rise_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Level flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        level_d = level_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/switch_entry.sv
// Debounced switch/pushbutton hex-word entry; four nibbles committed with enter.
// SWITCH_ENTRY_PREVIEW_EN builds the live accumulator echo on preview.
module switch_entry
    import switch_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned CNT_W           = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NIB_W-1:0]  switch,
    input  logic              btn_enter,
    input  logic              btn_clear,
    output logic [WORD_W-1:0] data_out,
    output logic              data_valid,
    output logic [IDX_W-1:0]  digit_idx,
    output logic              busy,
    output logic [WORD_W-1:0] preview
);

    logic [NIB_W-1:0] sw_level;
    logic [NIB_W-1:0] sw_rise_unused;
    logic             enter_level_unused, clear_level_unused;
    logic             enter_press, clear_press;

    debounce_sync #(.WIDTH(NIB_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_sw (
        .clk(clk), .rst_n(reset), .din(switch), .level(sw_level), .rise(sw_rise_unused)
    );
    debounce_sync #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_enter (
        .clk(clk), .rst_n(reset), .din(btn_enter), .level(enter_level_unused), .rise(enter_press)
    );
    debounce_sync #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear (
        .clk(clk), .rst_n(reset), .din(btn_clear), .level(clear_level_unused), .rise(clear_press)
    );

    state_e            state_q, state_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] data_out_q, data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              busy_q, busy_d;

    // Entry FSM; a clear press overrides everything else in the same cycle.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enter_press) begin
                    acc_d   = {(WORD_W - NIB_W)'(0), sw_level};
                    idx_d   = IDX_W'(1);
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (enter_press) begin
                    acc_d[{idx_q, 2'b00} +: NIB_W] = sw_level;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NIBBLES - 1)) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                data_out_d   = acc_q;
                data_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear_press) begin
            acc_d        = '0;
            idx_d        = '0;
            state_d      = ST_IDLE;
            data_out_d   = data_out_q;
            data_valid_d = 1'b0;
        end
        busy_d = (idx_d != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            idx_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            idx_q        <= idx_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign digit_idx  = idx_q;
    assign busy       = busy_q;

`ifdef SWITCH_ENTRY_PREVIEW_EN
    logic [WORD_W-1:0] preview_q, preview_d;

    // Accumulator with the pending nibble replaced by the live switch value.
    always_comb begin
        preview_d = acc_d;
        preview_d[{idx_d, 2'b00} +: NIB_W] = sw_level;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) preview_q <= '0;
        else        preview_q <= preview_d;
    end

    assign preview = preview_q;
`else
    assign preview = '0;
`endif

endmodule

// File: tb/tb_switch_entry.sv
// Directed self-checking bench for switch_entry with a short debounce window.
module tb_switch_entry;

    logic        clk;
    logic        reset;
    logic [3:0]  switch;
    logic        btn_enter;
    logic        btn_clear;
    logic [15:0] data_out;
    logic        data_valid;
    logic [1:0]  digit_idx;
    logic        busy;
    logic [15:0] preview;

    int total = 0;
    int bad   = 0;
    int valid_cnt = 0;
    int preview_nz = 0;

    switch_entry #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .switch(switch),
        .btn_enter(btn_enter), .btn_clear(btn_clear),
        .data_out(data_out), .data_valid(data_valid),
        .digit_idx(digit_idx), .busy(busy), .preview(preview)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid === 1'b1) valid_cnt++;
        if (preview !== 16'h0000) preview_nz++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic enter_nibble(input logic [3:0] nib);
        switch = nib;
        cycles(8);
        btn_enter = 1'b1;
        cycles(10);
        btn_enter = 1'b0;
        cycles(10);
    endtask

    task automatic press_clear();
        btn_clear = 1'b1;
        cycles(10);
        btn_clear = 1'b0;
        cycles(10);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            switch    = 4'(i * 5 + 3);
            btn_enter = ~btn_enter;
            btn_clear = ~btn_clear;
            @(negedge clk);
        end
        total++;
        if (data_out !== 16'h0000) begin bad++; $display("FAIL reset_data_out got=%h exp=0000", data_out); end
        total++;
        if (digit_idx !== 2'd0 || busy !== 1'b0) begin bad++; $display("FAIL reset_idx got idx=%0d busy=%b exp 0/0", digit_idx, busy); end
        total++;
        if (data_valid !== 1'b0 || preview !== 16'h0000) begin bad++; $display("FAIL reset_valid_preview got v=%b p=%h exp 0/0000", data_valid, preview); end
        switch = 4'h0; btn_enter = 1'b0; btn_clear = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cycles(12);
        total++;
        if (digit_idx !== 2'd0 || valid_cnt !== 0 || data_out !== 16'h0000) begin
            bad++; $display("FAIL reset_release got idx=%0d vcnt=%0d data=%h exp 0/0/0000", digit_idx, valid_cnt, data_out);
        end
    endtask

    task automatic test_full_entry();
        int v0;
        v0 = valid_cnt;
        enter_nibble(4'h1);
        enter_nibble(4'h2);
        total++;
        if (digit_idx !== 2'd2 || busy !== 1'b1) begin bad++; $display("FAIL full_mid got idx=%0d busy=%b exp 2/1", digit_idx, busy); end
        enter_nibble(4'h3);
        enter_nibble(4'h4);
        total++;
        if (data_out !== 16'h4321) begin bad++; $display("FAIL full_data got=%h exp=4321", data_out); end
        total++;
        if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL full_valid_pulses got=%0d exp=1", valid_cnt - v0); end
        total++;
        if (digit_idx !== 2'd0 || busy !== 1'b0) begin bad++; $display("FAIL full_idle got idx=%0d busy=%b exp 0/0", digit_idx, busy); end
    endtask

    task automatic test_bounce();
        int v0;
        v0 = valid_cnt;
        switch = 4'h6;
        cycles(8);
        for (int i = 0; i < 6; i++) begin
            btn_enter = ~btn_enter;
            cycles(2);
        end
        btn_enter = 1'b1;
        cycles(2);
        switch = 4'hF;
        cycles(2);
        switch = 4'h6;
        cycles(8);
        total++;
        if (digit_idx !== 2'd1) begin bad++; $display("FAIL bounce_one_press got idx=%0d exp=1", digit_idx); end
        btn_enter = 1'b0;
        cycles(10);
        enter_nibble(4'h7);
        enter_nibble(4'h8);
        enter_nibble(4'h9);
        total++;
        if (data_out !== 16'h9876) begin bad++; $display("FAIL bounce_glitch_nibble got=%h exp=9876", data_out); end
        total++;
        if (valid_cnt - v0 !== 1) begin bad++; $display("FAIL bounce_valid_pulses got=%0d exp=1", valid_cnt - v0); end
    endtask

    task automatic test_clear_mid();
        int v0;
        v0 = valid_cnt;
        enter_nibble(4'hA);
        enter_nibble(4'hB);
        press_clear();
        total++;
        if (digit_idx !== 2'd0 || busy !== 1'b0) begin bad++; $display("FAIL clear_idx got idx=%0d busy=%b exp 0/0", digit_idx, busy); end
        total++;
        if (data_out !== 16'h9876 || valid_cnt !== v0) begin
            bad++; $display("FAIL clear_hold got data=%h vcnt=%0d exp 9876/%0d", data_out, valid_cnt, v0);
        end
        enter_nibble(4'h1);
        enter_nibble(4'h2);
        enter_nibble(4'h3);
        enter_nibble(4'h4);
        total++;
        if (data_out !== 16'h4321) begin bad++; $display("FAIL clear_reentry got=%h exp=4321", data_out); end
    endtask

    task automatic test_simultaneous();
        int v0;
        v0 = valid_cnt;
        enter_nibble(4'h5);
        enter_nibble(4'h6);
        switch = 4'hE;
        cycles(8);
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        cycles(10);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        cycles(10);
        total++;
        if (digit_idx !== 2'd0 || busy !== 1'b0) begin bad++; $display("FAIL simul_idx got idx=%0d busy=%b exp 0/0", digit_idx, busy); end
        total++;
        if (data_out !== 16'h4321 || valid_cnt !== v0) begin
            bad++; $display("FAIL simul_no_valid got data=%h vcnt=%0d exp 4321/%0d", data_out, valid_cnt, v0);
        end
        enter_nibble(4'hC);
        enter_nibble(4'hD);
        enter_nibble(4'hE);
        enter_nibble(4'hF);
        total++;
        if (data_out !== 16'hFEDC) begin bad++; $display("FAIL simul_next_word got=%h exp=fedc", data_out); end
    endtask

    task automatic test_preview();
        enter_nibble(4'h7);
        switch = 4'h5;
        cycles(8);
`ifdef SWITCH_ENTRY_PREVIEW_EN
        total++;
        if (preview !== 16'h0057) begin bad++; $display("FAIL preview_live got=%h exp=0057", preview); end
        press_clear();
        total++;
        if (preview !== 16'h0005) begin bad++; $display("FAIL preview_cleared got=%h exp=0005", preview); end
`else
        total++;
        if (preview !== 16'h0000) begin bad++; $display("FAIL preview_tied got=%h exp=0000", preview); end
        press_clear();
        total++;
        if (preview_nz !== 0) begin bad++; $display("FAIL preview_never_set got=%0d cycles exp=0", preview_nz); end
`endif
    endtask

    initial begin
        reset     = 1'b0;
        switch    = 4'h0;
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        test_reset();
        test_full_entry();
        test_bounce();
        test_clear_mid();
        test_simultaneous();
        test_preview();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
